// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM encoding and the counter sizing helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } arb_state_e;

    localparam int unsigned GAP_CYCLES_DEF  = 217;
    localparam int unsigned ACK_TIMEOUT_DEF = 8;

    // Width able to hold 0..n, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester, transmitter and status bundle of the UART TX arbiter.
// The arbiter takes the slave view; the surrounding logic the master view.
interface uart_tx_arbiter_if;

    logic        req0_valid;
    logic        req1_valid;
    logic [7:0]  req0_data;
    logic [7:0]  req1_data;
    logic        req0_ready;
    logic        req1_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        grant;
    logic        active;
    logic        timeout_err;
    logic [15:0] frame_count;

    modport slave (
        input  req0_valid,
        input  req1_valid,
        input  req0_data,
        input  req1_data,
        output req0_ready,
        output req1_ready,
        output tx_start,
        output tx_data,
        input  tx_busy,
        output grant,
        output active,
        output timeout_err,
        output frame_count
    );

    modport master (
        output req0_valid,
        output req1_valid,
        output req0_data,
        output req1_data,
        input  req0_ready,
        input  req1_ready,
        input  tx_start,
        input  tx_data,
        output tx_busy,
        input  grant,
        input  active,
        input  timeout_err,
        input  frame_count
    );

endinterface

// File: rtl/uart_rr_pick2.sv
// Two-way round-robin picker: the requester not granted last wins a tie.
// A lone valid always wins.
module uart_rr_pick2
    import uart_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_i,
    output logic any_o,
    output logic winner_o
);

    assign any_o    = valid0_i | valid1_i;
    assign winner_o = (valid0_i & valid1_i) ? ~last_i : valid1_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte requesters onto one UART transmitter,
// with start handshake, ack timeout and an inter-frame gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    uart_tx_arbiter_if.slave bus_io
);

    localparam int unsigned GW = cnt_w(GAP_CYCLES);
    localparam int unsigned WW = cnt_w(ACK_TIMEOUT);

    arb_state_e    state_q;
    arb_state_e    state_d;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_d;
    logic [WW-1:0] wait_q;
    logic [WW-1:0] wait_d;
    logic [7:0]    data_q;
    logic [7:0]    data_d;
    logic          grant_q;
    logic          grant_d;
    logic          last_q;
    logic          last_d;
    logic          tmo_q;
    logic          tmo_d;
    logic [15:0]   frame_count_q;
    logic [15:0]   frame_count_d;

    logic any;
    logic winner;
    logic accept;

    uart_rr_pick2 u_pick (
        .valid0_i (bus_io.req0_valid),
        .valid1_i (bus_io.req1_valid),
        .last_i   (last_q),
        .any_o    (any),
        .winner_o (winner)
    );

    // Ready is combinational; gated by reset so it drops with reset_n.
    assign accept = reset_n && (state_q == ST_IDLE) && any;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            gap_q         <= '0;
            wait_q        <= '0;
            data_q        <= '0;
            grant_q       <= 1'b0;
            last_q        <= 1'b1;
            tmo_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            wait_q        <= wait_d;
            data_q        <= data_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            tmo_q         <= tmo_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        wait_d        = wait_q;
        data_d        = data_q;
        grant_d       = grant_q;
        last_d        = last_q;
        tmo_d         = 1'b0;
        frame_count_d = frame_count_q;
        unique case (state_q)
            ST_IDLE: begin
                gap_d  = '0;
                wait_d = '0;
                if (any) begin
                    data_d  = winner ? bus_io.req1_data
                                     : bus_io.req0_data;
                    grant_d = winner;
                    last_d  = winner;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                wait_d  = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus_io.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (int'(wait_q) + 1 >= ACK_TIMEOUT) begin
                    tmo_d   = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus_io.tx_busy) begin
                    frame_count_d = frame_count_q + 16'd1;
                    gap_d         = '0;
                    state_d       = ST_GAP;
                end
            end
            ST_GAP: begin
                // A zero-length gap still spends one cycle here.
                if (int'(gap_q) + 1 >= GAP_CYCLES) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_io.req0_ready  = accept & ~winner;
    assign bus_io.req1_ready  = accept & winner;
    assign bus_io.tx_start    = (state_q == ST_START);
    assign bus_io.tx_data     = data_q;
    assign bus_io.grant       = grant_q;
    assign bus_io.active      = (state_q != ST_IDLE);
    assign bus_io.timeout_err = tmo_q;
    assign bus_io.frame_count = frame_count_q;

    a_one_ready: assert property (@(posedge clock) disable iff (!reset_n)
        !(bus_io.req0_ready && bus_io.req1_ready));

    a_ready_idle: assert property (@(posedge clock) disable iff (!reset_n)
        (bus_io.req0_ready || bus_io.req1_ready) |-> state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model.
// Expected values are hand-derived cycle counts and bytes.
module tb_uart_tx_arbiter;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus_io  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit   tx_en = 1'b1;
    int   busy_len = 20;
    logic mdl_busy;
    logic mdl_dly;
    int   bcnt;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit hs0;
    bit hs1;

    int         acc_id[$];
    int         acc_cyc[$];
    int         st_cyc[$];
    logic [7:0] st_data[$];
    logic       st_grant[$];
    int         to_cyc[$];
    int         fall_cyc = 0;
    logic       busy_prev = 1'b0;
    int         rel_cyc;

    logic [7:0] exp_d[4];
    logic       exp_g[4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nclk(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic clr_logs();
        acc_id.delete();
        acc_cyc.delete();
        st_cyc.delete();
        st_data.delete();
        st_grant.delete();
        to_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        nclk(3);
        clr_logs();
        reset_n = 1'b1;
        nclk(1);
    endtask

    always @(posedge clock) cyc++;

    // Transmitter: busy rises two clocks after start, lasts busy_len clocks.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mdl_busy <= 1'b0;
            mdl_dly  <= 1'b0;
            bcnt     <= 0;
        end else begin
            mdl_dly <= tx_en && bus.tx_start;
            if (mdl_dly) begin
                mdl_busy <= 1'b1;
                bcnt     <= busy_len - 1;
            end else if (mdl_busy) begin
                if (bcnt == 0) mdl_busy <= 1'b0;
                else bcnt <= bcnt - 1;
            end
        end
    end
    assign bus.tx_busy = mdl_busy;

    always @(negedge clock) begin
        hs0 = bus.req0_valid && bus.req0_ready;
        hs1 = bus.req1_valid && bus.req1_ready;
        if (hs0) begin
            acc_id.push_back(0);
            acc_cyc.push_back(cyc);
        end
        if (hs1) begin
            acc_id.push_back(1);
            acc_cyc.push_back(cyc);
        end
        if (bus.tx_start) begin
            st_cyc.push_back(cyc);
            st_data.push_back(bus.tx_data);
            st_grant.push_back(bus.grant);
        end
        if (bus.timeout_err) to_cyc.push_back(cyc);
        if (busy_prev && !bus.tx_busy) fall_cyc = cyc;
        busy_prev = bus.tx_busy;
    end

    // Requester feeders: hold valid with the queue head until accepted.
    initial forever begin
        @(posedge clock);
        #1;
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        hs0 = 1'b0;
        hs1 = 1'b0;
        bus.req0_valid = (q0.size() > 0);
        bus.req1_valid = (q1.size() > 0);
        if (q0.size() > 0) bus.req0_data = q0[0];
        if (q1.size() > 0) bus.req1_data = q1[0];
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_data  = 8'h00;
        exp_d = '{8'h55, 8'hC3, 8'h11, 8'h22};
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        reset_n = 1'b0;
        nclk(3);

        chk("rst_active", bus.active, 0);
        chk("rst_txstart", bus.tx_start, 0);
        chk("rst_txdata", bus.tx_data, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_fc", bus.frame_count, 0);
        chk("rst_tmo", bus.timeout_err, 0);
        reset_n = 1'b1;
        nclk(2);
        chk("idle_active", bus.active, 0);

        // Single requester, long frame, then gap timing.
        tx_en = 1'b1;
        busy_len = 2170;
        q0.push_back(8'hAA);
        for (int i = 0; i < 3000 && bus.frame_count != 16'd1; i++) nclk();
        chk("t1_fc", bus.frame_count, 1);
        chk("t1_nacc", acc_id.size(), 1);
        chk("t1_nstart", st_cyc.size(), 1);
        if (acc_id.size() == 1 && st_cyc.size() == 1) begin
            chk("t1_id", acc_id[0], 0);
            chk("t1_lat", st_cyc[0] - acc_cyc[0], 1);
            chk("t1_data", st_data[0], 8'hAA);
            chk("t1_grant", st_grant[0], 0);
        end
        busy_len = 20;
        q0.push_back(8'hBB);
        for (int i = 0; i < 400 && acc_id.size() < 2; i++) nclk();
        chk("t1_acc2", acc_id.size(), 2);
        if (acc_cyc.size() == 2) chk("t1_gap", acc_cyc[1] - fall_cyc, 218);
        for (int i = 0; i < 400 && bus.frame_count != 16'd2; i++) nclk();
        chk("t1_fc2", bus.frame_count, 2);

        // Contention from reset: alternating grants over four frames.
        do_reset();
        busy_len = 20;
        q0.push_back(8'h55);
        q0.push_back(8'h11);
        q1.push_back(8'hC3);
        q1.push_back(8'h22);
        for (int i = 0; i < 1500 && bus.frame_count != 16'd4; i++) nclk();
        chk("t3_fc", bus.frame_count, 4);
        chk("t3_nstart", st_cyc.size(), 4);
        for (int i = 0; i < 4 && i < st_data.size(); i++) begin
            chk($sformatf("t3_data%0d", i), st_data[i], exp_d[i]);
            chk($sformatf("t3_grant%0d", i), st_grant[i], exp_g[i]);
        end

        // Ack timeout: transmitter never answers.
        do_reset();
        tx_en = 1'b0;
        q0.push_back(8'h77);
        for (int i = 0; i < 300 && to_cyc.size() == 0; i++) nclk();
        chk("t4_seen", to_cyc.size(), 1);
        if (to_cyc.size() > 0 && st_cyc.size() > 0)
            chk("t4_lat", to_cyc[0] - (st_cyc[0] + 1), 8);
        chk("t4_fc", bus.frame_count, 0);
        nclk();
        chk("t4_pulse", bus.timeout_err, 0);
        nclk(215);
        chk("t4_gap_act", bus.active, 1);
        nclk();
        chk("t4_idle", bus.active, 0);
        tx_en = 1'b1;
        q0.push_back(8'h66);
        q1.push_back(8'h99);
        for (int i = 0; i < 20 && st_cyc.size() < 2; i++) nclk();
        chk("t4_nstart", st_cyc.size(), 2);
        if (st_cyc.size() == 2) begin
            chk("t4_rr_grant", st_grant[1], 1);
            chk("t4_rr_data", st_data[1], 8'h99);
        end

        // Reset in WAIT_DONE with req1 pending.
        do_reset();
        tx_en = 1'b1;
        busy_len = 50;
        q1.push_back(8'h99);
        for (int i = 0; i < 30 && !bus.tx_busy; i++) nclk();
        nclk(3);
        q1.push_back(8'h5A);
        nclk(2);
        chk("t5_ready_busy", bus.req1_ready, 0);
        chk("t5_hold_data", bus.tx_data, 8'h99);
        chk("t5_grant", bus.grant, 1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_active", bus.active, 0);
        chk("t5_txdata", bus.tx_data, 0);
        chk("t5_rgrant", bus.grant, 0);
        chk("t5_ready", bus.req1_ready, 0);
        chk("t5_txstart", bus.tx_start, 0);
        chk("t5_fc", bus.frame_count, 0);
        clr_logs();
        nclk(4);
        chk("t5_nostart", st_cyc.size(), 0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        rel_cyc = cyc;
        for (int i = 0; i < 10 && st_cyc.size() == 0; i++) nclk();
        chk("t5_nacc", acc_id.size(), 1);
        if (acc_id.size() == 1) begin
            chk("t5_acc_id", acc_id[0], 1);
            chk("t5_acc_cyc", acc_cyc[0] - rel_cyc, 0);
        end
        if (st_cyc.size() > 0) begin
            chk("t5_sdata", st_data[0], 8'h5A);
            chk("t5_sgrant", st_grant[0], 1);
        end

        // frame_count wrap from 0xFFFF.
        for (int i = 0; i < 200 && bus.frame_count != 16'd1; i++) nclk();
        chk("t6_fc1", bus.frame_count, 1);
        for (int i = 0; i < 300 && bus.active; i++) nclk();
        force dut.frame_count_d = 16'hFFFF;
        @(posedge clock);
        #1;
        release dut.frame_count_d;
        nclk();
        chk("t6_pre", bus.frame_count, 16'hFFFF);
        q0.push_back(8'h3C);
        for (int i = 0; i < 400 && bus.frame_count == 16'hFFFF; i++) nclk();
        chk("t6_wrap", bus.frame_count, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
